// File: rtl/alu_issue_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_issue_stage: issue/writeback stage between an 8x32 register file and |
// | an external combinational ALU, with WB-to-issue operand bypass.         |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module alu_issue_stage (
  input  logic        clk,
  input  logic        rstN,
  input  logic        instValid,
  output logic        instReady,
  input  logic [6:0]  instOp,
  input  logic [2:0]  instRa,
  input  logic [2:0]  instRb,
  input  logic [2:0]  instRd,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [6:0]  controlUnitOut,
  output logic        issueValid,
  input  logic [31:0] aluOut,
  input  logic [2:0]  dbgAddr,
  output logic [31:0] dbgData,
  output logic        illegalOp,
  output logic [15:0] instCount
);

  localparam logic [6:0]  C_FIRST_ILLEGAL_OP = 7'd7;
  localparam logic [15:0] C_COUNT_MAX        = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WB    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [6:0]  op_q, op_d;
  logic [2:0]  rd_q, rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        illegal_q, illegal_d;
  logic [15:0] count_q, count_d;
  logic [31:0] rf_q [8];
  logic [31:0] rf_d [8];

  logic        w_accept;
  logic        w_wb_writes;
  logic [31:0] w_opnd_a;
  logic [31:0] w_opnd_b;

  assign instReady      = (state_q != S_ISSUE);
  assign issueValid     = (state_q == S_ISSUE);
  assign A              = a_q;
  assign B              = b_q;
  assign controlUnitOut = op_q;
  assign illegalOp      = illegal_q;
  assign instCount      = count_q;
  // r0 is never written, so a plain read already returns 0 for it
  assign dbgData        = rf_q[dbgAddr];

  always_comb begin
    w_accept    = instValid && (state_q != S_ISSUE);
    // op_q still holds the retiring instruction's opcode during WB
    w_wb_writes = (state_q == S_WB) && (rd_q != 3'd0) && (op_q < C_FIRST_ILLEGAL_OP);
    w_opnd_a    = (w_wb_writes && (instRa == rd_q)) ? wb_data_q : rf_q[instRa];
    w_opnd_b    = (w_wb_writes && (instRb == rd_q)) ? wb_data_q : rf_q[instRb];
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    rd_d      = rd_q;
    wb_data_d = wb_data_q;
    illegal_d = illegal_q;
    count_d   = count_q;
    rf_d      = rf_q;

    case (state_q)
      S_IDLE: begin
        if (w_accept) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        wb_data_d = aluOut;
        state_d   = S_WB;
      end
      S_WB: begin
        if (w_wb_writes) rf_d[rd_q] = wb_data_q;
        if (count_q != C_COUNT_MAX) count_d = count_q + 16'd1;
        state_d = w_accept ? S_ISSUE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (w_accept) begin
      a_d  = w_opnd_a;
      b_d  = w_opnd_b;
      op_d = instOp;
      rd_d = instRd;
      if (instOp >= C_FIRST_ILLEGAL_OP) illegal_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      wb_data_q <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      wb_data_q <= wb_data_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
      rf_q      <= rf_d;
    end
  end

endmodule
`default_nettype wire
